// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage F/D/E/M/W pipeline: memory wait, multi-cycle ops,
// branch squash and load-use bubbles. Optional perf counters enabled by HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int TO_W       = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  RA1D,
    input  logic [3:0]  RA2D,
    input  logic [3:0]  A3_addrE,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        PCSrcE,
    input  logic        MCycleOpE,
    input  logic        MCycleDone,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        FlushW,
    output logic        MCycleStart,
    output logic        MCycleAbort,
    output logic        HazErr
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] PerfLd,
    output logic [31:0] PerfBr,
    output logic [31:0] PerfMc,
    output logic [31:0] PerfMem
`endif
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_MC_BUSY  = 2'd2;
    localparam logic [1:0] S_LD_BUB   = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      r_ret_state;
    logic [TO_W-1:0] r_cnt;
    logic            r_hazerr;

    logic [1:0]      w_next_state;
    logic [1:0]      w_next_ret;
    logic [TO_W-1:0] w_next_cnt;
    logic            w_set_err;
    logic            w_memwait;
    logic            w_ldstall;
    logic            w_to_hit;
    logic            w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic            w_flush_d, w_flush_e, w_flush_m, w_flush_w;
    logic            w_start, w_abort;

    assign w_memwait = MemReqM & ~MemReadyM;
    assign w_ldstall = MemtoRegE & RegWriteE & ((RA1D == A3_addrE) | (RA2D == A3_addrE));
    assign w_to_hit  = (r_cnt == TO_W'(MC_TIMEOUT - 1));

    always_comb begin
        w_next_state = r_state;
        w_next_ret   = r_ret_state;
        w_next_cnt   = r_cnt;
        w_set_err    = 1'b0;
        w_stall_f    = 1'b0;
        w_stall_d    = 1'b0;
        w_stall_e    = 1'b0;
        w_stall_m    = 1'b0;
        w_flush_d    = 1'b0;
        w_flush_e    = 1'b0;
        w_flush_m    = 1'b0;
        w_flush_w    = 1'b0;
        w_start      = 1'b0;
        w_abort      = 1'b0;
        if (w_memwait) begin
            // Freeze the whole pipe; only the first wait cycle records where to resume.
            w_stall_f    = 1'b1;
            w_stall_d    = 1'b1;
            w_stall_e    = 1'b1;
            w_stall_m    = 1'b1;
            w_flush_w    = 1'b1;
            w_next_state = S_MEM_WAIT;
            if (r_state != S_MEM_WAIT) begin
                w_next_ret = r_state;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (MCycleOpE) begin
                        w_start      = 1'b1;
                        w_stall_f    = 1'b1;
                        w_stall_d    = 1'b1;
                        w_stall_e    = 1'b1;
                        w_flush_m    = 1'b1;
                        w_next_cnt   = '0;
                        w_next_state = S_MC_BUSY;
                    end else if (PCSrcE) begin
                        w_flush_d = 1'b1;
                        w_flush_e = 1'b1;
                    end else if (w_ldstall) begin
                        w_stall_f    = 1'b1;
                        w_stall_d    = 1'b1;
                        w_flush_e    = 1'b1;
                        w_next_state = S_LD_BUB;
                    end
                end
                S_MC_BUSY: begin
                    if (MCycleDone) begin
                        w_next_state = S_RUN;
                    end else if (w_to_hit) begin
                        w_abort      = 1'b1;
                        w_flush_e    = 1'b1;
                        w_set_err    = 1'b1;
                        w_next_state = S_RUN;
                    end else begin
                        w_stall_f  = 1'b1;
                        w_stall_d  = 1'b1;
                        w_stall_e  = 1'b1;
                        w_flush_m  = 1'b1;
                        w_next_cnt = r_cnt + TO_W'(1);
                    end
                end
                S_MEM_WAIT: w_next_state = r_ret_state;
                S_LD_BUB:   w_next_state = S_RUN;
                default:    w_next_state = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_ret_state <= S_RUN;
            r_cnt       <= '0;
            r_hazerr    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_ret_state <= w_next_ret;
            r_cnt       <= w_next_cnt;
            r_hazerr    <= r_hazerr | w_set_err;
        end
    end

    // Outputs are forced low while reset is held, independent of the hazard inputs.
    assign StallF      = rst_n & w_stall_f;
    assign StallD      = rst_n & w_stall_d;
    assign StallE      = rst_n & w_stall_e;
    assign StallM      = rst_n & w_stall_m;
    assign FlushD      = rst_n & w_flush_d;
    assign FlushE      = rst_n & w_flush_e;
    assign FlushM      = rst_n & w_flush_m;
    assign FlushW      = rst_n & w_flush_w;
    assign MCycleStart = rst_n & w_start;
    assign MCycleAbort = rst_n & w_abort;
    assign HazErr      = r_hazerr;

`ifdef HAZ_PERF_CNT_EN
    logic        w_cause_ld, w_cause_br, w_cause_mc, w_cause_mem;
    logic [31:0] r_cnt_ld, r_cnt_br, r_cnt_mc, r_cnt_mem;

    assign w_cause_mem = w_memwait;
    assign w_cause_mc  = ~w_memwait & (((r_state == S_RUN) & MCycleOpE) |
                                       ((r_state == S_MC_BUSY) & ~MCycleDone));
    assign w_cause_br  = ~w_memwait & (r_state == S_RUN) & ~MCycleOpE & PCSrcE;
    assign w_cause_ld  = ~w_memwait & (r_state == S_RUN) & ~MCycleOpE & ~PCSrcE & w_ldstall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_ld  <= '0;
            r_cnt_br  <= '0;
            r_cnt_mc  <= '0;
            r_cnt_mem <= '0;
        end else begin
            if (w_cause_ld  && (r_cnt_ld  != '1)) r_cnt_ld  <= r_cnt_ld  + 32'd1;
            if (w_cause_br  && (r_cnt_br  != '1)) r_cnt_br  <= r_cnt_br  + 32'd1;
            if (w_cause_mc  && (r_cnt_mc  != '1)) r_cnt_mc  <= r_cnt_mc  + 32'd1;
            if (w_cause_mem && (r_cnt_mem != '1)) r_cnt_mem <= r_cnt_mem + 32'd1;
        end
    end

    assign PerfLd  = r_cnt_ld;
    assign PerfBr  = r_cnt_br;
    assign PerfMc  = r_cnt_mc;
    assign PerfMem = r_cnt_mem;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios, then randomized traffic
// checked against a behavioural model of the pipeline's wait/multicycle/bubble rules.
module tb_pipe_hazard_ctrl;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] RA1D = '0, RA2D = '0, A3_addrE = '0;
    logic       RegWriteE = 1'b0, MemtoRegE = 1'b0, PCSrcE = 1'b0, MCycleOpE = 1'b0;
    logic       MCycleDone = 1'b0, MemReqM = 1'b0, MemReadyM = 1'b0;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
    logic       MCycleStart, MCycleAbort, HazErr;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] PerfLd, PerfBr, PerfMc, PerfMem;
`endif

    pipe_hazard_ctrl #(.MC_TIMEOUT(TO), .TO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .RA1D(RA1D), .RA2D(RA2D), .A3_addrE(A3_addrE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .PCSrcE(PCSrcE),
        .MCycleOpE(MCycleOpE), .MCycleDone(MCycleDone), .MemReqM(MemReqM),
        .MemReadyM(MemReadyM), .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .FlushW(FlushW), .MCycleStart(MCycleStart), .MCycleAbort(MCycleAbort),
        .HazErr(HazErr)
`ifdef HAZ_PERF_CNT_EN
        , .PerfLd(PerfLd), .PerfBr(PerfBr), .PerfMc(PerfMc), .PerfMem(PerfMem)
`endif
    );

    always #5 clk = ~clk;

    // Expected vector: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,Start,Abort,HazErr}
    logic [10:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    // Behavioural model: a memory wait pauses everything; otherwise an active multi-cycle op
    // owns the pipe, a pending load bubble drains, or the RUN priorities apply.
    bit m_hold, m_mc, m_bub, m_err;
    int m_age;

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
                MCycleStart, MCycleAbort, HazErr};
    endfunction

    task automatic apply(input bit rv, input logic [3:0] ra1, input logic [3:0] ra2,
                         input logic [3:0] a3, input bit rw, input bit mtr, input bit pcs,
                         input bit mcop, input bit done, input bit req, input bit rdy);
        logic [10:0] e;
        bit sf, sd, se, sm, fd, fe, fm, fw, st, ab;
        @(negedge clk);
        rst_n = rv; RA1D = ra1; RA2D = ra2; A3_addrE = a3; RegWriteE = rw; MemtoRegE = mtr;
        PCSrcE = pcs; MCycleOpE = mcop; MCycleDone = done; MemReqM = req; MemReadyM = rdy;
        {sf, sd, se, sm, fd, fe, fm, fw, st, ab} = '0;
        if (!rv) begin
            m_hold = 0; m_mc = 0; m_bub = 0; m_err = 0; m_age = 0;
            e = '0;
        end else begin
            e = '0;
            e[0] = m_err;
            if (req && !rdy) begin
                {sf, sd, se, sm, fw} = 5'b11111;
                m_hold = 1;
            end else if (m_hold) begin
                m_hold = 0;
            end else if (m_mc) begin
                if (done) m_mc = 0;
                else if (m_age == TO - 1) begin
                    ab = 1; fe = 1; m_err = 1; m_mc = 0;
                end else begin
                    {sf, sd, se, fm} = 4'b1111;
                    m_age++;
                end
            end else if (m_bub) begin
                m_bub = 0;
            end else if (mcop) begin
                {st, sf, sd, se, fm} = 5'b11111;
                m_mc = 1; m_age = 0;
            end else if (pcs) begin
                fd = 1; fe = 1;
            end else if (mtr && rw && (ra1 == a3 || ra2 == a3)) begin
                sf = 1; sd = 1; fe = 1; m_bub = 1;
            end
            e[10:1] = {sf, sd, se, sm, fd, fe, fm, fw, st, ab};
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic busy(input int n);
        for (int i = 0; i < n; i++) apply(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle, sampled well after the driving negedge.
    initial begin
        logic [10:0] a, e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
                     MCycleStart, MCycleAbort, HazErr};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL ctrl_outputs cycle %0d got=%b expected=%b (StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,Start,Abort,HazErr)",
                             cyc, a, e);
                end
                cyc++;
            end
        end
    end

    initial begin
        // Reset with provocative inputs: outputs must stay low.
        apply(0, 2, 2, 2, 1, 1, 1, 1, 0, 1, 0);
        #1;
        chk("reset_state", outs(), 11'b0);
        apply(0, 2, 2, 2, 1, 1, 1, 1, 0, 1, 0);
        idle(2);
        // Load-use, then the bubble cycle, then normal RUN.
        apply(1, 2, 5, 2, 1, 1, 0, 0, 0, 0, 0);
        apply(1, 2, 5, 2, 1, 1, 0, 0, 0, 0, 0);
        idle(2);
        // Load-use coincident with a taken branch.
        apply(1, 2, 5, 2, 1, 1, 1, 0, 0, 0, 0);
        idle(2);
        // Multi-cycle op finishing after 5 busy cycles.
        apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        busy(5);
        apply(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        idle(2);
        // Memory wait in the middle of a multi-cycle op.
        apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        busy(2);
        for (int i = 0; i < 3; i++) apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        busy(2);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        // Multi-cycle timeout: abort on the TO-th busy cycle, sticky error afterwards.
        apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        busy(TO - 1);
        busy(1);
        #1;
        chk("expired_wait_abort", outs(), 11'b00000100010);
        busy(3);
        #1;
        chk("expired_wait_hazerr", {10'b0, HazErr}, 11'b1);
        idle(2);
        // Load bubble interrupted by a memory wait; ready with no request is ignored.
        apply(1, 3, 3, 3, 1, 1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(2);
        // Reset mid multi-cycle op clears the error flag.
        apply(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        busy(2);
        apply(0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0);
        #1;
        chk("reset_mid_busy", outs(), 11'b0);
        apply(0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0);
        idle(2);
        #1;
        chk("reset_release_hazerr", {10'b0, HazErr}, 11'b0);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            apply(($urandom_range(0, 499) != 0),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
